// File: rtl/ysyx_2022040010_axi_bridge.sv
// Arbitrates icache/dcache/uncache requests into single-beat 64-bit AXI4 read/write transactions, one outstanding.
// Latency (request sampled to refresh): read 3, write 3, dcache write-back + refill 5 cycles minimum.
// Backpressure: the core holds its request until refresh; each AXI valid holds until its own handshake.
// Ports: per-requester re/we/addr/data/mask in, data_o + one-cycle refresh_o out;
//        AXI AW/W/B/AR/R master channels (len 0, 64-bit, INCR tied off downstream); sticky bus_err_o.
module ysyx_2022040010_axi_bridge #(
  parameter int         ADDR_W = 64,
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_re_i,
  input  logic [ADDR_W-1:0] icache_addr_i,
  output logic [63:0]       icache_data_o,
  output logic              icache_refresh_o,
  input  logic              dcache_re_i,
  input  logic              dcache_we_i,
  input  logic [7:0]        dcache_mask_i,
  input  logic [ADDR_W-1:0] dcache_addr_i,
  input  logic [63:0]       dcache_olddata_i,
  output logic [63:0]       dcache_newdata_o,
  output logic              dcache_refresh_o,
  input  logic              uncache_re_i,
  input  logic              uncache_we_i,
  input  logic [7:0]        uncache_mask_i,
  input  logic [ADDR_W-1:0] uncache_addr_i,
  input  logic [63:0]       uncache_wdata_i,
  output logic [63:0]       uncache_rdata_o,
  output logic              uncache_refresh_o,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  output logic [ADDR_W-1:0] axi_awaddr,
  output logic [3:0]        axi_awid,
  output logic              axi_wvalid,
  input  logic              axi_wready,
  output logic [63:0]       axi_wdata,
  output logic [7:0]        axi_wstrb,
  output logic              axi_wlast,
  input  logic              axi_bvalid,
  output logic              axi_bready,
  input  logic [1:0]        axi_bresp,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic [3:0]        axi_arid,
  input  logic              axi_rvalid,
  output logic              axi_rready,
  input  logic [63:0]       axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rlast,
  output logic              bus_err_o
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;
  typedef enum logic [1:0] {REQ_IC, REQ_DC, REQ_UC} req_t;

  state_t state;
  req_t   gnt_id;
  logic   gnt_re;   // dcache miss with dirty victim: refill follows the write-back

  // Single-beat transfers: every data beat is the last one.
  assign axi_awid  = AXI_ID;
  assign axi_arid  = AXI_ID;
  assign axi_wlast = axi_wvalid;

  // rlast carries no information for len-0 bursts.
  logic unused_rlast;
  assign unused_rlast = axi_rlast;

  // Fixed priority: dcache > uncache > icache.
  logic              sel_vld;
  req_t              sel_id;
  logic              sel_re;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [63:0]       sel_wdata;
  logic [7:0]        sel_mask;

  always_comb begin
    sel_vld   = 1'b1;
    sel_id    = REQ_IC;
    sel_re    = icache_re_i;
    sel_we    = 1'b0;
    sel_addr  = icache_addr_i;
    sel_wdata = '0;
    sel_mask  = '0;
    if (dcache_re_i || dcache_we_i) begin
      sel_id    = REQ_DC;
      sel_re    = dcache_re_i;
      sel_we    = dcache_we_i;
      sel_addr  = dcache_addr_i;
      sel_wdata = dcache_olddata_i;
      sel_mask  = dcache_mask_i;
    end else if (uncache_re_i || uncache_we_i) begin
      sel_id    = REQ_UC;
      sel_re    = uncache_re_i;
      sel_we    = uncache_we_i;
      sel_addr  = uncache_addr_i;
      sel_wdata = uncache_wdata_i;
      sel_mask  = uncache_mask_i;
    end else if (!icache_re_i) begin
      sel_vld = 1'b0;
    end
  end

  // AW and W retire independently; a channel whose valid already dropped counts as done.
  logic aw_done;
  logic w_done;
  assign aw_done = !axi_awvalid || axi_awready;
  assign w_done  = !axi_wvalid  || axi_wready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      gnt_id            <= REQ_IC;
      gnt_re            <= 1'b0;
      axi_awvalid       <= 1'b0;
      axi_awaddr        <= '0;
      axi_wvalid        <= 1'b0;
      axi_wdata         <= '0;
      axi_wstrb         <= '0;
      axi_bready        <= 1'b0;
      axi_arvalid       <= 1'b0;
      axi_araddr        <= '0;
      axi_rready        <= 1'b0;
      icache_data_o     <= '0;
      dcache_newdata_o  <= '0;
      uncache_rdata_o   <= '0;
      icache_refresh_o  <= 1'b0;
      dcache_refresh_o  <= 1'b0;
      uncache_refresh_o <= 1'b0;
      bus_err_o         <= 1'b0;
    end else begin
      icache_refresh_o  <= 1'b0;
      dcache_refresh_o  <= 1'b0;
      uncache_refresh_o <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_vld) begin
            // The AXI address/data/strobe registers double as the grant register.
            gnt_id <= sel_id;
            gnt_re <= sel_re;
            if (sel_we) begin
              axi_awaddr  <= sel_addr;
              axi_wdata   <= sel_wdata;
              axi_wstrb   <= sel_mask;
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
              state       <= WADDR;
            end else begin
              axi_araddr  <= sel_addr;
              axi_arvalid <= 1'b1;
              state       <= RADDR;
            end
          end
        end
        WADDR: begin
          if (axi_awready) axi_awvalid <= 1'b0;
          if (axi_wready)  axi_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            axi_bready <= 1'b1;
            state      <= WRESP;
          end
        end
        WRESP: begin
          if (axi_bvalid) begin
            axi_bready <= 1'b0;
            if (axi_bresp != 2'b00) bus_err_o <= 1'b1;
            if (gnt_id == REQ_DC && gnt_re) begin
              // The core swaps dcache_addr_i from victim to refill address during the write-back.
              axi_araddr  <= dcache_addr_i;
              axi_arvalid <= 1'b1;
              state       <= RADDR;
            end else begin
              icache_refresh_o  <= (gnt_id == REQ_IC);
              dcache_refresh_o  <= (gnt_id == REQ_DC);
              uncache_refresh_o <= (gnt_id == REQ_UC);
              state             <= DONE;
            end
          end
        end
        RADDR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state       <= RDATA;
          end
        end
        RDATA: begin
          if (axi_rvalid) begin
            axi_rready <= 1'b0;
            if (axi_rresp != 2'b00) bus_err_o <= 1'b1;
            case (gnt_id)
              REQ_IC:  icache_data_o    <= axi_rdata;
              REQ_DC:  dcache_newdata_o <= axi_rdata;
              default: uncache_rdata_o  <= axi_rdata;
            endcase
            icache_refresh_o  <= (gnt_id == REQ_IC);
            dcache_refresh_o  <= (gnt_id == REQ_DC);
            uncache_refresh_o <= (gnt_id == REQ_UC);
            state             <= DONE;
          end
        end
        // Requests are not sampled here, so a request still high during its refresh is not re-issued.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_2022040010_axi_bridge.sv
// Self-checking bench for ysyx_2022040010_axi_bridge: vector table plus hand sequences,
// with an AXI slave model and scoreboards for refresh/data and AW/W/AR contents.
module tb_ysyx_2022040010_axi_bridge;

  localparam logic [63:0] Z64 = 64'h0;

  logic        clk;
  logic        rst;
  logic        icache_re_i;
  logic [63:0] icache_addr_i;
  logic [63:0] icache_data_o;
  logic        icache_refresh_o;
  logic        dcache_re_i;
  logic        dcache_we_i;
  logic [7:0]  dcache_mask_i;
  logic [63:0] dcache_addr_i;
  logic [63:0] dcache_olddata_i;
  logic [63:0] dcache_newdata_o;
  logic        dcache_refresh_o;
  logic        uncache_re_i;
  logic        uncache_we_i;
  logic [7:0]  uncache_mask_i;
  logic [63:0] uncache_addr_i;
  logic [63:0] uncache_wdata_i;
  logic [63:0] uncache_rdata_o;
  logic        uncache_refresh_o;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [63:0] axi_awaddr;
  logic [3:0]  axi_awid;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [1:0]  axi_bresp;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [63:0] axi_araddr;
  logic [3:0]  axi_arid;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        bus_err_o;

  ysyx_2022040010_axi_bridge dut (
    .clk(clk), .rst(rst),
    .icache_re_i(icache_re_i), .icache_addr_i(icache_addr_i),
    .icache_data_o(icache_data_o), .icache_refresh_o(icache_refresh_o),
    .dcache_re_i(dcache_re_i), .dcache_we_i(dcache_we_i), .dcache_mask_i(dcache_mask_i),
    .dcache_addr_i(dcache_addr_i), .dcache_olddata_i(dcache_olddata_i),
    .dcache_newdata_o(dcache_newdata_o), .dcache_refresh_o(dcache_refresh_o),
    .uncache_re_i(uncache_re_i), .uncache_we_i(uncache_we_i), .uncache_mask_i(uncache_mask_i),
    .uncache_addr_i(uncache_addr_i), .uncache_wdata_i(uncache_wdata_i),
    .uncache_rdata_o(uncache_rdata_o), .uncache_refresh_o(uncache_refresh_o),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr), .axi_awid(axi_awid),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arid(axi_arid),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast),
    .bus_err_o(bus_err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // who: 0 icache, 1 dcache, 2 uncache. lat = cycles from request drive to refresh.
  typedef struct {
    int          who;
    logic        re;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] refill;
    logic [7:0]  mask;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    int          ar_dly;
    int          r_dly;
    logic [1:0]  resp;
    int          lat;
    logic        err;
  } vec_t;

  typedef struct {
    int          who;
    logic [63:0] data;
    int          t0;
    int          lat;
  } exp_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  strb;
  } wexp_t;

  exp_t        sb[$];
  logic [63:0] awq[$];
  wexp_t       wq[$];
  logic [63:0] arq[$];

  int          checks;
  int          errors;
  int          cyc;
  int          nref;
  int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [1:0]  cur_resp;
  logic [63:0] slave_raddr;
  logic [63:0] dc_refill;
  logic [63:0] last_rd [3];

  function automatic logic [63:0] rmodel(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h0000_0013_0000_0093;
    return {~a[31:0], a[31:0]};
  endfunction

  function automatic logic [63:0] data_of(input int who);
    if (who == 0) return icache_data_o;
    if (who == 1) return dcache_newdata_o;
    return uncache_data_sel();
  endfunction

  function automatic logic [63:0] uncache_data_sel();
    return uncache_rdata_o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // One clock: monitor outputs, release refreshed requesters, then the slave picks its next response.
  task automatic tick();
    int          nr;
    int          who;
    exp_t        e;
    wexp_t       w;
    logic [63:0] a;
    @(negedge clk);
    cyc++;
    nr = int'(icache_refresh_o) + int'(dcache_refresh_o) + int'(uncache_refresh_o);
    if (nr > 0) begin
      chk("refresh_onehot", 64'(nr), 64'd1);
      who = icache_refresh_o ? 0 : (dcache_refresh_o ? 1 : 2);
      nref++;
      if (sb.size() == 0) begin
        fail_now("refresh_unexpected", $sformatf("requester %0d pulsed with nothing pending", who));
      end else begin
        e = sb.pop_front();
        chk("refresh_who", 64'(who), 64'(e.who));
        chk("refresh_data", data_of(who), e.data);
        chk("refresh_latency", 64'(cyc - e.t0), 64'(e.lat));
      end
      if (who == 0) icache_re_i = 1'b0;
      if (who == 1) begin dcache_re_i = 1'b0; dcache_we_i = 1'b0; end
      if (who == 2) begin uncache_re_i = 1'b0; uncache_we_i = 1'b0; end
    end
    if (axi_wvalid) chk("wlast", 64'(axi_wlast), 64'd1);
    if ((axi_arvalid || axi_rready) && (axi_awvalid || axi_wvalid || axi_bready))
      fail_now("rw_overlap", "read and write channels active together");
    if (axi_bready && dcache_re_i && dcache_we_i) dcache_addr_i = dc_refill;

    if (axi_awvalid) begin
      axi_awready = (aw_cnt >= aw_dly);
      aw_cnt++;
      if (axi_awready) begin
        aw_cnt = 0;
        chk("awid", 64'(axi_awid), Z64);
        if (awq.size() == 0) fail_now("aw_unexpected", $sformatf("addr %h", axi_awaddr));
        else begin a = awq.pop_front(); chk("awaddr", axi_awaddr, a); end
      end
    end else begin
      axi_awready = 1'b0;
      aw_cnt = 0;
    end

    if (axi_wvalid) begin
      axi_wready = (w_cnt >= w_dly);
      w_cnt++;
      if (axi_wready) begin
        w_cnt = 0;
        if (wq.size() == 0) fail_now("w_unexpected", $sformatf("data %h", axi_wdata));
        else begin
          w = wq.pop_front();
          chk("wdata", axi_wdata, w.data);
          chk("wstrb", 64'(axi_wstrb), 64'(w.strb));
        end
      end
    end else begin
      axi_wready = 1'b0;
      w_cnt = 0;
    end

    if (axi_bready) begin
      axi_bvalid = (b_cnt >= b_dly);
      axi_bresp  = axi_bvalid ? cur_resp : 2'b00;
      b_cnt++;
    end else begin
      axi_bvalid = 1'b0;
      axi_bresp  = 2'b00;
      b_cnt = 0;
    end

    if (axi_arvalid) begin
      axi_arready = (ar_cnt >= ar_dly);
      ar_cnt++;
      if (axi_arready) begin
        ar_cnt = 0;
        slave_raddr = axi_araddr;
        chk("arid", 64'(axi_arid), Z64);
        if (arq.size() == 0) fail_now("ar_unexpected", $sformatf("addr %h", axi_araddr));
        else begin a = arq.pop_front(); chk("araddr", axi_araddr, a); end
      end
    end else begin
      axi_arready = 1'b0;
      ar_cnt = 0;
    end

    if (axi_rready) begin
      axi_rvalid = (r_cnt >= r_dly);
      axi_rdata  = rmodel(slave_raddr);
      axi_rresp  = axi_rvalid ? cur_resp : 2'b00;
      axi_rlast  = axi_rvalid;
      r_cnt++;
    end else begin
      axi_rvalid = 1'b0;
      axi_rdata  = Z64;
      axi_rresp  = 2'b00;
      axi_rlast  = 1'b0;
      r_cnt = 0;
    end
  endtask

  // Drive a request and push everything it should produce onto the scoreboards.
  task automatic launch(input int who, input logic re, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] refill, input logic [7:0] mask,
                        input int lat);
    exp_t        e;
    wexp_t       w;
    logic [63:0] ra;
    e.who = who;
    e.t0  = cyc;
    e.lat = lat;
    if (we) begin
      awq.push_back(addr);
      w.data = wdata;
      w.strb = mask;
      wq.push_back(w);
    end
    if (re) begin
      ra = we ? refill : addr;
      arq.push_back(ra);
      e.data = rmodel(ra);
      last_rd[who] = e.data;
    end else begin
      e.data = last_rd[who];
    end
    sb.push_back(e);
    if (who == 0) begin
      icache_addr_i = addr;
      icache_re_i   = 1'b1;
    end else if (who == 1) begin
      dcache_addr_i    = addr;
      dcache_olddata_i = wdata;
      dcache_mask_i    = mask;
      dc_refill        = refill;
      dcache_re_i      = re;
      dcache_we_i      = we;
    end else begin
      uncache_addr_i  = addr;
      uncache_wdata_i = wdata;
      uncache_mask_i  = mask;
      uncache_re_i    = re;
      uncache_we_i    = we;
    end
  endtask

  task automatic run(input int n, input int budget, input string name);
    int target;
    int k;
    target = nref + n;
    k = 0;
    while (nref < target && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (nref < target) begin
      errors++;
      $display("FAIL %s_timeout: %0d of %0d refreshes within %0d cycles", name, nref + n - target, n, budget);
    end
  endtask

  task automatic chk_drained(input string name);
    chk(name, 64'(sb.size() + awq.size() + wq.size() + arq.size()), Z64);
  endtask

  vec_t v [11];

  initial begin
    checks = 0; errors = 0; cyc = 0; nref = 0;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    cur_resp = 2'b00; slave_raddr = Z64; dc_refill = Z64;
    for (int i = 0; i < 3; i++) last_rd[i] = Z64;
    icache_re_i = 1'b0; icache_addr_i = Z64;
    dcache_re_i = 1'b0; dcache_we_i = 1'b0; dcache_mask_i = 8'h00;
    dcache_addr_i = Z64; dcache_olddata_i = Z64;
    uncache_re_i = 1'b0; uncache_we_i = 1'b0; uncache_mask_i = 8'h00;
    uncache_addr_i = Z64; uncache_wdata_i = Z64;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = Z64; axi_rresp = 2'b00; axi_rlast = 1'b0;

    //            who re    we    addr                  wdata                   refill                mask   aw w b ar r resp  lat err
    v[0]  = '{0, 1'b1, 1'b0, 64'h0000_0000_8000_0000, Z64,                    Z64,                   8'h00, 0, 0, 0, 0, 0, 2'b00, 3, 1'b0};
    v[1]  = '{2, 1'b0, 1'b1, 64'h0000_0000_a000_03f8, 64'h41,                 Z64,                   8'h01, 3, 0, 0, 0, 0, 2'b00, 6, 1'b0};
    v[2]  = '{1, 1'b1, 1'b1, 64'h0000_0000_8000_1000, 64'hdead_beef,          64'h0000_0000_8000_2000, 8'hff, 0, 0, 0, 0, 0, 2'b00, 5, 1'b0};
    v[3]  = '{2, 1'b1, 1'b0, 64'h0000_0000_a000_0100, Z64,                    Z64,                   8'h00, 0, 0, 0, 2, 1, 2'b00, 6, 1'b0};
    v[4]  = '{1, 1'b1, 1'b0, 64'h0000_0000_8000_3008, Z64,                    Z64,                   8'h00, 0, 0, 0, 0, 0, 2'b00, 3, 1'b0};
    v[5]  = '{1, 1'b0, 1'b1, 64'h0000_0000_8000_4000, 64'h1122_3344_5566_7788, Z64,                  8'hf0, 0, 2, 1, 0, 0, 2'b00, 6, 1'b0};
    v[6]  = '{2, 1'b0, 1'b1, 64'h0000_0000_a000_0020, 64'h0000_00ff_0000_00aa, Z64,                  8'h0f, 1, 1, 0, 0, 0, 2'b00, 4, 1'b0};
    v[7]  = '{0, 1'b1, 1'b0, 64'h0000_0000_8000_0040, Z64,                    Z64,                   8'h00, 0, 0, 0, 0, 3, 2'b00, 6, 1'b0};
    v[8]  = '{1, 1'b1, 1'b1, 64'h0000_0000_8000_5000, 64'hcafe_f00d_0000_0001, 64'h0000_0000_8000_6000, 8'hff, 1, 0, 1, 1, 1, 2'b00, 9, 1'b0};
    v[9]  = '{0, 1'b1, 1'b0, 64'h0000_0000_8000_0080, Z64,                    Z64,                   8'h00, 0, 0, 0, 0, 0, 2'b10, 3, 1'b1};
    v[10] = '{2, 1'b0, 1'b1, 64'h0000_0000_a000_0030, 64'h5,                  Z64,                   8'h01, 0, 0, 0, 0, 0, 2'b00, 3, 1'b1};

    // Reset state.
    rst = 1'b1;
    #1 rst = 1'b0;
    tick(); tick();
    chk("rst_awvalid", 64'(axi_awvalid), Z64);
    chk("rst_wvalid", 64'(axi_wvalid), Z64);
    chk("rst_bready", 64'(axi_bready), Z64);
    chk("rst_arvalid", 64'(axi_arvalid), Z64);
    chk("rst_rready", 64'(axi_rready), Z64);
    chk("rst_refresh", 64'({icache_refresh_o, dcache_refresh_o, uncache_refresh_o}), Z64);
    chk("rst_icache_data", icache_data_o, Z64);
    chk("rst_dcache_data", dcache_newdata_o, Z64);
    chk("rst_uncache_data", uncache_rdata_o, Z64);
    chk("rst_awaddr", axi_awaddr, Z64);
    chk("rst_araddr", axi_araddr, Z64);
    chk("rst_wdata", axi_wdata, Z64);
    chk("rst_wstrb", 64'(axi_wstrb), Z64);
    chk("rst_bus_err", 64'(bus_err_o), Z64);
    rst = 1'b1;
    tick();

    // Table-driven single transactions.
    for (int i = 0; i < 11; i++) begin
      aw_dly = v[i].aw_dly; w_dly = v[i].w_dly; b_dly = v[i].b_dly;
      ar_dly = v[i].ar_dly; r_dly = v[i].r_dly; cur_resp = v[i].resp;
      launch(v[i].who, v[i].re, v[i].we, v[i].addr, v[i].wdata, v[i].refill, v[i].mask, v[i].lat);
      run(1, 60, $sformatf("vec%0d", i));
      tick(); tick();
      chk($sformatf("vec%0d_bus_err", i), 64'(bus_err_o), 64'(v[i].err));
      chk_drained($sformatf("vec%0d_drained", i));
    end

    // All three requesters in the same cycle: served dcache, uncache, icache, 4 cycles apart.
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; cur_resp = 2'b00;
    launch(1, 1'b1, 1'b0, 64'h8000_7000, Z64, Z64, 8'h00, 3);
    launch(2, 1'b0, 1'b1, 64'ha000_0040, 64'h77, Z64, 8'h80, 7);
    launch(0, 1'b1, 1'b0, 64'h8000_00c0, Z64, Z64, 8'h00, 11);
    run(3, 80, "concurrent");
    tick(); tick();
    chk_drained("concurrent_drained");

    // Asynchronous reset while waiting in RDATA.
    r_dly = 20;
    arq.push_back(64'h8000_0100);
    icache_addr_i = 64'h8000_0100;
    icache_re_i = 1'b1;
    for (int k = 0; k < 10 && !axi_rready; k++) tick();
    chk("rdata_reached", 64'(axi_rready), 64'd1);
    rst = 1'b0;
    #1;
    chk("midrst_rready", 64'(axi_rready), Z64);
    chk("midrst_arvalid", 64'(axi_arvalid), Z64);
    chk("midrst_bus_err", 64'(bus_err_o), Z64);
    chk("midrst_icache_data", icache_data_o, Z64);
    chk("midrst_dcache_data", dcache_newdata_o, Z64);
    icache_re_i = 1'b0;
    for (int i = 0; i < 3; i++) last_rd[i] = Z64;
    tick(); tick();
    rst = 1'b1;
    tick();
    r_dly = 0;
    launch(0, 1'b1, 1'b0, 64'h8000_0000, Z64, Z64, 8'h00, 3);
    run(1, 40, "post_reset");
    tick(); tick();
    chk("post_reset_bus_err", 64'(bus_err_o), Z64);
    chk_drained("post_reset_drained");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
